click_counter_db: RTL and testbench
===================================

// Module: click_counter_db
// PURPOSE
//  Debounced up/down click counter, system-clocked successor to the switch-clocked counter.
//  Samples two raw active-low push-buttons on the board clock, synchronises and debounces
//  them, and turns each press into a one-cycle event that steps a WIDTH-bit counter.
//  Counter drives LEDs or downstream logic; event pulses are exported for other blocks.
// PARAMETERS
//  WIDTH       8       counter width in bits (>=2)
//  DEB_CYCLES  120000  clocks a synchronised input must hold a new level before it is
//                      accepted (10 ms at 12 MHz); >=2
//  SATURATE    0       0: wrap-around at limits; 1: clamp at 0 and 2**WIDTH-1
// PORTS
//  clk       in   1      system clock, all logic on rising edge
//  rst       in   1      asynchronous reset, active-low
//  btn_up    in   1      raw up button, active-low (0 = pressed), asynchronous to clk
//  btn_down  in   1      raw down button, active-low, asynchronous to clk
//  clr       in   1      synchronous clear, active-high
//  count     out  WIDTH  current counter value
//  up_evt    out  1      one-cycle pulse: accepted up press
//  down_evt  out  1      one-cycle pulse: accepted down press
//  ovf       out  1      sticky overflow flag   (only with CLICK_CNT_FLAGS_EN)
//  unf       out  1      sticky underflow flag  (only with CLICK_CNT_FLAGS_EN)
// BEHAVIOUR
//  - Reset (rst=0, async): count=0, up_evt=down_evt=0, ovf=unf=0; synchroniser FFs and
//    debounced state = 1 (released); debounce counters = 0.
//  - Sync: per button 2-FF synchroniser; no logic reads the first stage.
//  - Debounce per channel: cnt clears when sync==stable; else increments each clock; on
//    cnt==DEB_CYCLES-1 stable<=sync, cnt<=0. Glitch shorter than DEB_CYCLES never accepted.
//  - Event: stable 1->0 (press) gives evt=1 for exactly one clock, cycle after the
//    transition; release (0->1) gives no event. Held button = single event, no repeat.
//  - Latency raw edge -> evt: 2 (sync) + DEB_CYCLES + 1 clocks; count updates on the
//    same edge that raises evt (count visible with evt).
//  - Counter priority per clock: clr > (up_evt & down_evt: no change) > up > down.
//  - Wrap (SATURATE=0): 2**WIDTH-1 +1 -> 0; 0 -1 -> 2**WIDTH-1. Arithmetic modulo 2**WIDTH.
//  - Saturate (SATURATE=1): up at max holds max; down at 0 holds 0.
//  - clr with a pending event: count=0, event pulses still asserted, step discarded.
//  - Button held across reset release: seen as a press, counted once after debounce.
//  - Reset mid-debounce: partial count discarded, channel restarts from released.
// CONFIGURATION
//  - CLICK_CNT_FLAGS_EN defined: ports ovf/unf exist. ovf sets when an up step wraps or
//    is clamped at max; unf sets when a down step wraps or is clamped at 0. Sticky until
//    clr or rst. Simultaneous up+down (no change) sets neither.
//  - Not defined: ovf/unf ports and their logic absent; all other behaviour identical.
// TESTING  (bench uses WIDTH=4, DEB_CYCLES=4)
//  1. rst=0 then release, buttons idle=1 -> count=0, no evt for 100 clocks.
//  2. btn_up low 20 clocks -> one up_evt 7 clocks after edge, count 0->1; release: no evt.
//  3. btn_up glitch low 3 clocks, x5 -> no up_evt, count unchanged.
//  4. SATURATE=0: 16 up presses from 0 -> count 0 (wrap), ovf=1; one down press -> 15, unf=0.
//  5. SATURATE=1: down press at 0 -> count 0, unf=1; clr -> count 0, ovf=unf=0.
//  6. up and down pressed same clock, count=5 -> both evt pulse, count stays 5; rst=0
//     mid-debounce of next press -> count 0, no evt after release of rst with buttons idle.

Source files
------------

// File: rtl/click_counter_db.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// click_counter_db
//
// Debounced up/down click counter. Two raw active-low push-buttons are sampled
// on the system clock, passed through a 2-FF synchroniser, and then debounced.
// Each accepted press becomes a one-cycle event that steps a WIDTH-bit counter.
//
// Parameters
//   WIDTH       counter width in bits (>= 2)
//   DEB_CYCLES  clocks a synchronised level must hold before it is accepted (>= 2)
//   SATURATE    0: wrap at the limits, 1: clamp at 0 and 2**WIDTH-1
//
// Optional feature
//   CLICK_CNT_FLAGS_EN  when defined, adds sticky ovf/unf flag outputs
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous reset, active-low
//   btn_up    in   raw up button, active-low, asynchronous to clk
//   btn_down  in   raw down button, active-low, asynchronous to clk
//   clr       in   synchronous clear, active-high
//   count     out  current counter value
//   up_evt    out  one-cycle pulse per accepted up press
//   down_evt  out  one-cycle pulse per accepted down press
//   ovf       out  sticky overflow flag   (CLICK_CNT_FLAGS_EN only)
//   unf       out  sticky underflow flag  (CLICK_CNT_FLAGS_EN only)
// -----------------------------------------------------------------------------
module click_counter_db #(
  parameter int WIDTH      = 8,
  parameter int DEB_CYCLES = 120000,
  parameter bit SATURATE   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             up_evt,
  output logic             down_evt
`ifdef CLICK_CNT_FLAGS_EN
  ,
  output logic             ovf,
  output logic             unf
`endif
);

  localparam int              CW       = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0]   DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  // Channel 0 = up, channel 1 = down.
  logic [1:0] btn_raw;
  logic [1:0] press;

  assign btn_raw = {btn_down, btn_up};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic          sync1_reg;
      logic          sync2_reg;
      logic          stable_reg;
      logic          stable_d_reg;
      logic [CW-1:0] cnt_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sync1_reg    <= 1'b1;
          sync2_reg    <= 1'b1;
          stable_reg   <= 1'b1;
          stable_d_reg <= 1'b1;
          cnt_reg      <= '0;
        end else begin
          sync1_reg    <= btn_raw[gi];
          sync2_reg    <= sync1_reg;
          stable_d_reg <= stable_reg;
          // Any return to the accepted level restarts the hold timer, so a
          // glitch shorter than DEB_CYCLES can never be accepted.
          if (sync2_reg == stable_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DEB_LAST) begin
            stable_reg <= sync2_reg;
            cnt_reg    <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      // High for the single cycle after stable falls; the event register and
      // the counter both act on it at the next edge, so they appear together.
      assign press[gi] = stable_d_reg & ~stable_reg;
    end
  endgenerate

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic             up_evt_reg;
  logic             down_evt_reg;
  logic             at_max;
  logic             at_min;

  assign at_max = (count_reg == CNT_MAX);
  assign at_min = (count_reg == '0);

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (press[0] && press[1]) begin
      count_next = count_reg;
    end else if (press[0]) begin
      if (at_max) count_next = SATURATE ? CNT_MAX : '0;
      else        count_next = count_reg + 1'b1;
    end else if (press[1]) begin
      if (at_min) count_next = SATURATE ? '0 : CNT_MAX;
      else        count_next = count_reg - 1'b1;
    end
  end

  // Event pulses are independent of clr: a clear discards the step, not the event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg    <= '0;
      up_evt_reg   <= 1'b0;
      down_evt_reg <= 1'b0;
    end else begin
      count_reg    <= count_next;
      up_evt_reg   <= press[0];
      down_evt_reg <= press[1];
    end
  end

  assign count    = count_reg;
  assign up_evt   = up_evt_reg;
  assign down_evt = down_evt_reg;

`ifdef CLICK_CNT_FLAGS_EN
  logic ovf_reg;
  logic unf_reg;
  logic ovf_next;
  logic unf_next;

  // A lone step at a limit either wraps or clamps; both count as a limit hit.
  always_comb begin
    ovf_next = ovf_reg;
    unf_next = unf_reg;
    if (clr) begin
      ovf_next = 1'b0;
      unf_next = 1'b0;
    end else begin
      if (press[0] && !press[1] && at_max) ovf_next = 1'b1;
      if (press[1] && !press[0] && at_min) unf_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_reg <= 1'b0;
      unf_reg <= 1'b0;
    end else begin
      ovf_reg <= ovf_next;
      unf_reg <= unf_next;
    end
  end

  assign ovf = ovf_reg;
  assign unf = unf_reg;
`endif

endmodule

// File: tb/tb_click_counter_db.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_click_counter_db
//
// Directed bench for click_counter_db with WIDTH=4, DEB_CYCLES=4. Two instances
// share the same stimulus: one wrapping (SATURATE=0), one clamping (SATURATE=1).
// Flag checks are present only when CLICK_CNT_FLAGS_EN is defined.
// -----------------------------------------------------------------------------
module tb_click_counter_db;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_up;
  logic       btn_down;
  logic       clr;

  logic [3:0] count_w, count_s;
  logic       up_evt_w, down_evt_w, up_evt_s, down_evt_s;
`ifdef CLICK_CNT_FLAGS_EN
  logic       ovf_w, unf_w, ovf_s, unf_s;
`endif

  int err_cnt = 0;
  int chk_cnt = 0;
  int ev_up   = 0;
  int ev_dn   = 0;
  int ev_both = 0;

  always #5 clk = ~clk;

  click_counter_db #(.WIDTH(4), .DEB_CYCLES(4), .SATURATE(1'b0)) dut_wrap (
    .clk      (clk),
    .rst      (rst),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .clr      (clr),
    .count    (count_w),
    .up_evt   (up_evt_w),
    .down_evt (down_evt_w)
`ifdef CLICK_CNT_FLAGS_EN
    ,
    .ovf      (ovf_w),
    .unf      (unf_w)
`endif
  );

  click_counter_db #(.WIDTH(4), .DEB_CYCLES(4), .SATURATE(1'b1)) dut_sat (
    .clk      (clk),
    .rst      (rst),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .clr      (clr),
    .count    (count_s),
    .up_evt   (up_evt_s),
    .down_evt (down_evt_s)
`ifdef CLICK_CNT_FLAGS_EN
    ,
    .ovf      (ovf_s),
    .unf      (unf_s)
`endif
  );

  task automatic check(input string tag, input int got, input int exp);
    chk_cnt++;
    if (got != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // One clock; outputs sampled 1 ns after the rising edge, events tallied.
  task automatic tick();
    @(posedge clk);
    #1;
    ev_up   += int'(up_evt_w);
    ev_dn   += int'(down_evt_w);
    ev_both += int'(up_evt_w & down_evt_w);
    if (up_evt_s != up_evt_w || down_evt_s != down_evt_w) begin
      chk_cnt++;
      err_cnt++;
      $display("FAIL evt_match: sat up/dn %0d/%0d wrap up/dn %0d/%0d",
               up_evt_s, down_evt_s, up_evt_w, down_evt_w);
    end
  endtask

  task automatic press(input bit up, input bit dn, input int hold);
    btn_up   = up ? 1'b0 : 1'b1;
    btn_down = dn ? 1'b0 : 1'b1;
    repeat (hold) tick();
    btn_up   = 1'b1;
    btn_down = 1'b1;
    repeat (12) tick();
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    rst      = 1'b0;
    btn_up   = 1'b1;
    btn_down = 1'b1;
    clr      = 1'b0;

    // 1. Reset state and idle quiet period.
    repeat (3) tick();
    check("rst_count", int'(count_w), 0);
    check("rst_up_evt", int'(up_evt_w), 0);
    check("rst_dn_evt", int'(down_evt_w), 0);
`ifdef CLICK_CNT_FLAGS_EN
    check("rst_ovf", int'(ovf_w), 0);
    check("rst_unf", int'(unf_w), 0);
`endif
    rst = 1'b1;
    ev_up = 0; ev_dn = 0;
    repeat (100) tick();
    check("idle_up_evts", ev_up, 0);
    check("idle_dn_evts", ev_dn, 0);
    check("idle_count", int'(count_w), 0);

    // 2. Single press: event exactly 7 clocks after the raw edge.
    btn_up = 1'b0;
    ev_up  = 0;
    repeat (6) tick();
    check("lat_early_evts", ev_up, 0);
    tick();
    check("lat_up_evt", int'(up_evt_w), 1);
    check("lat_count_w", int'(count_w), 1);
    check("lat_count_s", int'(count_s), 1);
    tick();
    check("pulse_width", int'(up_evt_w), 0);
    repeat (12) tick();
    check("held_no_repeat", ev_up, 1);
    btn_up = 1'b1;
    ev_up  = 0;
    repeat (20) tick();
    check("release_no_evt", ev_up, 0);
    check("release_count", int'(count_w), 1);

    // 3. Three-clock glitches are never accepted.
    ev_up = 0;
    repeat (5) begin
      btn_up = 1'b0;
      repeat (3) tick();
      btn_up = 1'b1;
      repeat (10) tick();
    end
    check("glitch_evts", ev_up, 0);
    check("glitch_count", int'(count_w), 1);

    // 4. Sixteen ups from 0: wrap to 0 / clamp at 15, then one down.
    pulse_clr();
    check("clr_count_w", int'(count_w), 0);
    check("clr_count_s", int'(count_s), 0);
    ev_up = 0;
    repeat (16) press(1'b1, 1'b0, 10);
    check("ups_evts", ev_up, 16);
    check("wrap_count", int'(count_w), 0);
    check("clamp_count", int'(count_s), 15);
`ifdef CLICK_CNT_FLAGS_EN
    check("wrap_ovf", int'(ovf_w), 1);
    check("clamp_ovf", int'(ovf_s), 1);
`endif
    ev_dn = 0;
    press(1'b0, 1'b1, 10);
    check("down_evts", ev_dn, 1);
    check("down_count_w", int'(count_w), 15);
    check("down_count_s", int'(count_s), 14);
`ifdef CLICK_CNT_FLAGS_EN
    check("down_unf_w", int'(unf_w), 0);
    check("down_unf_s", int'(unf_s), 0);
`endif

    // 5. Down at 0: clamp / wrap, underflow flags, then clr.
    pulse_clr();
`ifdef CLICK_CNT_FLAGS_EN
    check("clr_ovf_s", int'(ovf_s), 0);
`endif
    press(1'b0, 1'b1, 10);
    check("under_count_s", int'(count_s), 0);
    check("under_count_w", int'(count_w), 15);
`ifdef CLICK_CNT_FLAGS_EN
    check("under_unf_s", int'(unf_s), 1);
    check("under_unf_w", int'(unf_w), 1);
`endif
    pulse_clr();
    check("clr2_count_s", int'(count_s), 0);
    check("clr2_count_w", int'(count_w), 0);
`ifdef CLICK_CNT_FLAGS_EN
    check("clr2_ovf_s", int'(ovf_s), 0);
    check("clr2_unf_s", int'(unf_s), 0);
    check("clr2_unf_w", int'(unf_w), 0);
`endif

    // clr on the same edge as an event: pulse still seen, step discarded.
    btn_up = 1'b0;
    repeat (6) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_evt_pulse", int'(up_evt_w), 1);
    check("clr_evt_count", int'(count_w), 0);
    btn_up = 1'b1;
    repeat (20) tick();
    check("clr_evt_after", int'(count_w), 0);

    // 6. Simultaneous up+down at 5: both pulse together, no change.
    repeat (5) press(1'b1, 1'b0, 10);
    check("five_count_w", int'(count_w), 5);
    check("five_count_s", int'(count_s), 5);
    ev_up = 0; ev_dn = 0; ev_both = 0;
    press(1'b1, 1'b1, 10);
    check("both_same_cycle", ev_both, 1);
    check("both_up_evts", ev_up, 1);
    check("both_dn_evts", ev_dn, 1);
    check("both_count_w", int'(count_w), 5);
    check("both_count_s", int'(count_s), 5);
`ifdef CLICK_CNT_FLAGS_EN
    check("both_ovf", int'(ovf_w), 0);
    check("both_unf", int'(unf_w), 0);
`endif

    // Reset in the middle of a debounce: nothing survives.
    btn_up = 1'b0;
    repeat (4) tick();
    rst = 1'b0;
    #1;
    check("midrst_count_w", int'(count_w), 0);
    check("midrst_count_s", int'(count_s), 0);
    btn_up = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    ev_up = 0; ev_dn = 0;
    repeat (30) tick();
    check("postrst_up_evts", ev_up, 0);
    check("postrst_dn_evts", ev_dn, 0);
    check("postrst_count", int'(count_w), 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
